// File: rtl/pc_redirect_ctrl.sv
// Fetch PC sequencer: sequential advance, branch redirect with a wait for the
// instruction memory, halt, and misaligned-target trap.
//
// state      | meaning
// -----------+------------------------------------------------------------
// BOOT       | first cycle after reset, no fetch, pc held
// RUN        | normal fetch, pc advances by 2 when accepted
// REDIR_WAIT | redirect pending until the outstanding fetch is accepted
// HALT       | terminal stop, pc frozen, left only through reset
module pc_redirect_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        takeBranch,
  input  logic [15:0] branchTarget,
  input  logic        stall,
  input  logic        halt,
  input  logic        imem_ready,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic        fetch_req,
  output logic        flush,
  output logic        halted,
  output logic        err_misalign
);

  typedef enum logic [1:0] {
    S_BOOT       = 2'd0,
    S_RUN        = 2'd1,
    S_REDIR_WAIT = 2'd2,
    S_HALT       = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] pend_q, pend_d;
  logic        flush_q, flush_d;
  logic        err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      flush_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      flush_q <= flush_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    flush_d = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (halt) begin
          state_d = S_HALT;
          pend_d  = '0;
        end else if (takeBranch) begin
          // An odd target traps whether it would be applied now or parked.
          if (branchTarget[0]) begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end else if (imem_ready) begin
            pc_d    = branchTarget;
            flush_d = 1'b1;
          end else begin
            pend_d  = branchTarget;
            state_d = S_REDIR_WAIT;
          end
        end else if (!stall && imem_ready) begin
          pc_d = pc_q + 16'd2;
        end
      end
      S_REDIR_WAIT: begin
        if (halt) begin
          state_d = S_HALT;
          pend_d  = '0;
        end else if (takeBranch && branchTarget[0]) begin
          err_d   = 1'b1;
          state_d = S_HALT;
          pend_d  = '0;
        end else if (imem_ready) begin
          pc_d    = takeBranch ? branchTarget : pend_q;
          flush_d = 1'b1;
          state_d = S_RUN;
          pend_d  = '0;
        end else if (takeBranch) begin
          pend_d = branchTarget;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  always_comb begin
    fetch_req = 1'b0;
    halted    = 1'b0;
    unique case (state_q)
      S_RUN, S_REDIR_WAIT: fetch_req = 1'b1;
      S_HALT:              halted    = 1'b1;
      default:             fetch_req = 1'b0;
    endcase
  end

  assign pc           = pc_q;
  assign pc_plus2     = pc_q + 16'd2;
  assign flush        = flush_q;
  assign err_misalign = err_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: each task drives a scenario and checks
// hand-computed pc / flush / status values one clock after each edge.
module tb_pc_redirect_ctrl;

  logic        clk;
  logic        rst_n;
  logic        takeBranch;
  logic [15:0] branchTarget;
  logic        stall;
  logic        halt;
  logic        imem_ready;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        fetch_req;
  logic        flush;
  logic        halted;
  logic        err_misalign;

  int checks;
  int errors;

  pc_redirect_ctrl #(.RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .takeBranch   (takeBranch),
    .branchTarget (branchTarget),
    .stall        (stall),
    .halt         (halt),
    .imem_ready   (imem_ready),
    .pc           (pc),
    .pc_plus2     (pc_plus2),
    .fetch_req    (fetch_req),
    .flush        (flush),
    .halted       (halted),
    .err_misalign (err_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    takeBranch   = 1'b0;
    branchTarget = 16'h0000;
    stall        = 1'b0;
    halt         = 1'b0;
    imem_ready   = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Asserts reset mid-cycle, then releases it just after the next edge.
  task automatic apply_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    idle_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #12;
    checks++;
    if (pc !== 16'h0000 || fetch_req !== 1'b0 || flush !== 1'b0 || halted !== 1'b0 || err_misalign !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: pc=%h fetch=%b flush=%b halted=%b err=%b, want 0000 0 0 0 0", pc, fetch_req, flush, halted, err_misalign);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (fetch_req !== 1'b0 || pc !== 16'h0000) begin
      errors++;
      $display("FAIL boot_no_fetch: fetch=%b pc=%h, want 0 0000", fetch_req, pc);
    end
  endtask

  task automatic test_sequential();
    logic [15:0] exp_pc [3];
    exp_pc[0] = 16'h0000;
    exp_pc[1] = 16'h0002;
    exp_pc[2] = 16'h0004;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (pc !== exp_pc[i] || fetch_req !== 1'b1 || flush !== 1'b0) begin
        errors++;
        $display("FAIL seq_pc[%0d]: pc=%h fetch=%b flush=%b, want %h 1 0", i, pc, fetch_req, flush, exp_pc[i]);
      end
    end
    checks++;
    if (pc_plus2 !== 16'h0006) begin
      errors++;
      $display("FAIL pc_plus2: got %h, want 0006", pc_plus2);
    end
  endtask

  task automatic test_branch();
    takeBranch   = 1'b1;
    branchTarget = 16'h0100;
    step();
    checks++;
    if (pc !== 16'h0100 || flush !== 1'b1) begin
      errors++;
      $display("FAIL branch_apply: pc=%h flush=%b, want 0100 1", pc, flush);
    end
    idle_inputs();
    step();
    checks++;
    if (pc !== 16'h0102 || flush !== 1'b0) begin
      errors++;
      $display("FAIL branch_after: pc=%h flush=%b, want 0102 0", pc, flush);
    end
  endtask

  task automatic test_back_to_back();
    takeBranch   = 1'b1;
    branchTarget = 16'h0200;
    step();
    checks++;
    if (pc !== 16'h0200 || flush !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: pc=%h flush=%b, want 0200 1", pc, flush);
    end
    branchTarget = 16'h0400;
    step();
    checks++;
    if (pc !== 16'h0400 || flush !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: pc=%h flush=%b, want 0400 1", pc, flush);
    end
    idle_inputs();
    step();
    checks++;
    if (pc !== 16'h0402 || flush !== 1'b0) begin
      errors++;
      $display("FAIL b2b_after: pc=%h flush=%b, want 0402 0", pc, flush);
    end
  endtask

  task automatic test_redir_wait();
    takeBranch   = 1'b1;
    branchTarget = 16'h0200;
    imem_ready   = 1'b0;
    step();
    checks++;
    if (pc !== 16'h0402 || flush !== 1'b0 || fetch_req !== 1'b1) begin
      errors++;
      $display("FAIL wait_enter: pc=%h flush=%b fetch=%b, want 0402 0 1", pc, flush, fetch_req);
    end
    takeBranch = 1'b0;
    step();
    takeBranch   = 1'b1;
    branchTarget = 16'h0300;
    step();
    checks++;
    if (pc !== 16'h0402 || flush !== 1'b0 || fetch_req !== 1'b1) begin
      errors++;
      $display("FAIL wait_hold: pc=%h flush=%b fetch=%b, want 0402 0 1", pc, flush, fetch_req);
    end
    takeBranch = 1'b0;
    imem_ready = 1'b1;
    step();
    checks++;
    if (pc !== 16'h0300 || flush !== 1'b1) begin
      errors++;
      $display("FAIL wait_apply: pc=%h flush=%b, want 0300 1", pc, flush);
    end
    step();
    checks++;
    if (pc !== 16'h0302 || flush !== 1'b0) begin
      errors++;
      $display("FAIL wait_after: pc=%h flush=%b, want 0302 0", pc, flush);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    step();
    checks++;
    if (pc !== 16'h0302) begin
      errors++;
      $display("FAIL stall_hold: pc=%h, want 0302", pc);
    end
    stall      = 1'b0;
    imem_ready = 1'b0;
    step();
    checks++;
    if (pc !== 16'h0302) begin
      errors++;
      $display("FAIL not_ready_hold: pc=%h, want 0302", pc);
    end
    imem_ready   = 1'b1;
    stall        = 1'b1;
    takeBranch   = 1'b1;
    branchTarget = 16'h0500;
    step();
    checks++;
    if (pc !== 16'h0500 || flush !== 1'b1) begin
      errors++;
      $display("FAIL stall_vs_branch: pc=%h flush=%b, want 0500 1", pc, flush);
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    takeBranch   = 1'b1;
    branchTarget = 16'hFFFE;
    step();
    idle_inputs();
    checks++;
    if (pc !== 16'hFFFE || pc_plus2 !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_setup: pc=%h pc_plus2=%h, want FFFE 0000", pc, pc_plus2);
    end
    step();
    checks++;
    if (pc !== 16'h0000 || err_misalign !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL wrap_pc: pc=%h err=%b halted=%b, want 0000 0 0", pc, err_misalign, halted);
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (pc !== 16'h0000) begin
        errors++;
        $display("FAIL wrap_stall[%0d]: pc=%h, want 0000", i, pc);
      end
    end
    stall = 1'b0;
    step();
    checks++;
    if (pc !== 16'h0002) begin
      errors++;
      $display("FAIL stall_release: pc=%h, want 0002", pc);
    end
  endtask

  task automatic test_halt_in_wait();
    takeBranch   = 1'b1;
    branchTarget = 16'h0600;
    imem_ready   = 1'b0;
    step();
    takeBranch = 1'b0;
    halt       = 1'b1;
    imem_ready = 1'b1;
    step();
    checks++;
    if (halted !== 1'b1 || pc !== 16'h0002 || flush !== 1'b0 || fetch_req !== 1'b0) begin
      errors++;
      $display("FAIL wait_halt: halted=%b pc=%h flush=%b fetch=%b, want 1 0002 0 0", halted, pc, flush, fetch_req);
    end
    idle_inputs();
    apply_reset();
    step();
    checks++;
    if (pc !== 16'h0000 || fetch_req !== 1'b1 || flush !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_fetch: pc=%h fetch=%b flush=%b halted=%b, want 0000 1 0 0", pc, fetch_req, flush, halted);
    end
  endtask

  task automatic test_reset_in_wait();
    step();
    takeBranch   = 1'b1;
    branchTarget = 16'h0800;
    imem_ready   = 1'b0;
    step();
    idle_inputs();
    imem_ready = 1'b0;
    apply_reset();
    step();
    step();
    checks++;
    if (pc !== 16'h0002 || flush !== 1'b0) begin
      errors++;
      $display("FAIL reset_drops_pending: pc=%h flush=%b, want 0002 0", pc, flush);
    end
  endtask

  task automatic test_misalign();
    apply_reset();
    step();
    step();
    takeBranch   = 1'b1;
    branchTarget = 16'h0101;
    step();
    checks++;
    if (err_misalign !== 1'b1 || halted !== 1'b1 || pc !== 16'h0002 || flush !== 1'b0 || fetch_req !== 1'b0) begin
      errors++;
      $display("FAIL misalign_trap: err=%b halted=%b pc=%h flush=%b fetch=%b, want 1 1 0002 0 0", err_misalign, halted, pc, flush, fetch_req);
    end
    branchTarget = 16'h0700;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (err_misalign !== 1'b1 || halted !== 1'b1 || pc !== 16'h0002 || flush !== 1'b0) begin
        errors++;
        $display("FAIL misalign_sticky[%0d]: err=%b halted=%b pc=%h flush=%b, want 1 1 0002 0", i, err_misalign, halted, pc, flush);
      end
    end
    idle_inputs();
    apply_reset();
    checks++;
    if (err_misalign !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL misalign_clear: err=%b halted=%b, want 0 0", err_misalign, halted);
    end
  endtask

  task automatic test_halt_vs_branch();
    step();
    step();
    halt         = 1'b1;
    takeBranch   = 1'b1;
    branchTarget = 16'h0700;
    step();
    checks++;
    if (halted !== 1'b1 || pc !== 16'h0002 || fetch_req !== 1'b0 || flush !== 1'b0 || err_misalign !== 1'b0) begin
      errors++;
      $display("FAIL halt_wins: halted=%b pc=%h fetch=%b flush=%b err=%b, want 1 0002 0 0 0", halted, pc, fetch_req, flush, err_misalign);
    end
    halt = 1'b0;
    step();
    checks++;
    if (halted !== 1'b1 || pc !== 16'h0002 || flush !== 1'b0) begin
      errors++;
      $display("FAIL halt_ignores_inputs: halted=%b pc=%h flush=%b, want 1 0002 0", halted, pc, flush);
    end
    idle_inputs();
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pc !== 16'h0000 || halted !== 1'b0 || fetch_req !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: pc=%h halted=%b fetch=%b, want 0000 0 0", pc, halted, fetch_req);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sequential();
    test_branch();
    test_back_to_back();
    test_redir_wait();
    test_stall();
    test_wrap();
    test_halt_in_wait();
    test_reset_in_wait();
    test_misalign();
    test_halt_vs_branch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
